// File: rtl/imem_sync_loadable_if.sv
// Fetch and load bus of the synchronous instruction memory.
// master = PC/fetch stage or host loader, slave = the memory.
interface imem_sync_loadable_if;
  logic        ready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        fetch_misalign;
  logic        fetch_oor;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_err;

  modport master (
    input  ready, fetch_valid, fetch_instr, fetch_misalign, fetch_oor, ld_err,
    output fetch_req, fetch_addr, ld_valid, ld_addr, ld_data
  );

  modport slave (
    output ready, fetch_valid, fetch_instr, fetch_misalign, fetch_oor, ld_err,
    input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_data
  );
endinterface

// File: rtl/imem_sync_loadable.sv
// Synchronous RV32I instruction memory: registered fetch port with
// alignment/range checks, run-time load port, and a post-reset clear engine
// that fills every word with FILL_WORD.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing FILL_WORD to index clr_cnt, one word per edge
// ST_READY | fetch and load accepted; stays here until reset
module imem_sync_loadable #(
  parameter int          DEPTH          = 64,
  parameter logic [31:0] FILL_WORD      = 32'h0000_0013,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  imem_sync_loadable_if.slave bus
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);
  localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]   mem [DEPTH];

  logic [29:0]   f_idx, l_idx;
  logic          f_mis, f_oor, l_bad;
  logic          fetch_go, ld_go;
  logic          we;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;

  logic          fetch_valid_q, fetch_mis_q, fetch_oor_q, ld_err_q;
  logic [31:0]   fetch_instr_q;

  // Full 30-bit index compare so out-of-range addresses never alias.
  assign f_idx    = bus.fetch_addr[31:2];
  assign f_mis    = |bus.fetch_addr[1:0];
  assign f_oor    = (f_idx >= DEPTH_W);
  assign l_idx    = bus.ld_addr[31:2];
  assign l_bad    = (|bus.ld_addr[1:0]) || (l_idx >= DEPTH_W);
  assign fetch_go = bus.fetch_req && (state_q == ST_READY);
  assign ld_go    = bus.ld_valid  && (state_q == ST_READY);

  // State and clear counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state and the single write port mux (clear engine vs. loader).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    we        = 1'b0;
    wr_idx    = l_idx[AW-1:0];
    wr_data   = bus.ld_data;
    case (state_q)
      ST_CLEAR: begin
        we        = 1'b1;
        wr_idx    = clr_cnt_q;
        wr_data   = FILL_WORD;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
      end
      ST_READY: begin
        we = ld_go && !l_bad;
      end
    endcase
  end

  // Memory array write; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  // Registered fetch response and load error pulse; the read is read-first,
  // so a same-edge load to the same index returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      fetch_mis_q   <= 1'b0;
      fetch_oor_q   <= 1'b0;
      fetch_instr_q <= '0;
      ld_err_q      <= 1'b0;
    end else begin
      fetch_valid_q <= fetch_go;
      fetch_mis_q   <= fetch_go && f_mis;
      fetch_oor_q   <= fetch_go && f_oor;
      ld_err_q      <= ld_go && l_bad;
      if (fetch_go)
        fetch_instr_q <= (f_mis || f_oor) ? FILL_WORD : mem[f_idx[AW-1:0]];
    end
  end

  assign bus.ready          = (state_q == ST_READY);
  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.fetch_instr    = fetch_instr_q;
  assign bus.fetch_misalign = fetch_mis_q;
  assign bus.fetch_oor      = fetch_oor_q;
  assign bus.ld_err         = ld_err_q;

endmodule

// File: tb/tb_imem_sync_loadable.sv
module tb_imem_sync_loadable;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imem_sync_loadable_if bus0 ();
  imem_sync_loadable_if bus1 ();

  imem_sync_loadable #(.DEPTH(64), .FILL_WORD(32'h0000_0013), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  imem_sync_loadable #(.DEPTH(5), .FILL_WORD(32'h0000_0013), .CLEAR_ON_RESET(1'b0)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp_instr,
                           input logic exp_mis, input logic exp_oor);
    bus0.fetch_req  = 1'b1;
    bus0.fetch_addr = addr;
    tick();
    bus0.fetch_req  = 1'b0;
    chk({tag, "_valid"}, 32'(bus0.fetch_valid), 32'd1);
    chk({tag, "_instr"}, bus0.fetch_instr, exp_instr);
    chk({tag, "_mis"}, 32'(bus0.fetch_misalign), 32'(exp_mis));
    chk({tag, "_oor"}, 32'(bus0.fetch_oor), 32'(exp_oor));
  endtask

  task automatic ld(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic exp_err);
    bus0.ld_valid = 1'b1;
    bus0.ld_addr  = addr;
    bus0.ld_data  = data;
    tick();
    bus0.ld_valid = 1'b0;
    chk({tag, "_ld_err"}, 32'(bus0.ld_err), 32'(exp_err));
  endtask

  task automatic wait_clear(input bit chk_u1);
    for (int i = 1; i <= 64; i++) begin
      tick();
      chk("clr_ready", 32'(bus0.ready), 32'(i == 64));
      chk("clr_no_valid", 32'(bus0.fetch_valid), 32'd0);
      if (chk_u1 && i == 1) chk("nc_ready_first_edge", 32'(bus1.ready), 32'd1);
    end
  endtask

  initial begin
    bus0.fetch_req = 1'b0; bus0.fetch_addr = '0;
    bus0.ld_valid  = 1'b0; bus0.ld_addr    = '0; bus0.ld_data = '0;
    bus1.fetch_req = 1'b0; bus1.fetch_addr = '0;
    bus1.ld_valid  = 1'b0; bus1.ld_addr    = '0; bus1.ld_data = '0;

    #1;
    chk("rst_ready", 32'(bus0.ready), 32'd0);
    chk("rst_valid", 32'(bus0.fetch_valid), 32'd0);
    chk("rst_instr", bus0.fetch_instr, 32'd0);
    chk("rst_ld_err", 32'(bus0.ld_err), 32'd0);
    tick();
    tick();

    // Clear sequence with a fetch held the whole time.
    rst_n = 1'b1;
    bus0.fetch_req  = 1'b1;
    bus0.fetch_addr = 32'h0;
    wait_clear(1'b0);
    tick();
    bus0.fetch_req = 1'b0;
    chk("post_clr_valid", 32'(bus0.fetch_valid), 32'd1);
    chk("post_clr_instr", bus0.fetch_instr, 32'h0000_0013);
    chk("post_clr_mis", 32'(bus0.fetch_misalign), 32'd0);
    chk("post_clr_oor", 32'(bus0.fetch_oor), 32'd0);
    tick();
    chk("idle_valid", 32'(bus0.fetch_valid), 32'd0);
    chk("idle_hold", bus0.fetch_instr, 32'h0000_0013);

    // Load then back-to-back fetch.
    ld("ld0", 32'h0, 32'h0070_0113, 1'b0);
    ld("ld4", 32'h4, 32'h0020_8193, 1'b0);
    bus0.fetch_req  = 1'b1;
    bus0.fetch_addr = 32'h0;
    tick();
    bus0.fetch_addr = 32'h4;
    chk("b2b0_valid", 32'(bus0.fetch_valid), 32'd1);
    chk("b2b0_instr", bus0.fetch_instr, 32'h0070_0113);
    tick();
    bus0.fetch_req = 1'b0;
    chk("b2b1_valid", 32'(bus0.fetch_valid), 32'd1);
    chk("b2b1_instr", bus0.fetch_instr, 32'h0020_8193);
    tick();
    chk("b2b_end_valid", 32'(bus0.fetch_valid), 32'd0);
    chk("b2b_end_hold", bus0.fetch_instr, 32'h0020_8193);

    // Faults.
    fetch_chk("f_mis", 32'h2, 32'h0000_0013, 1'b1, 1'b0);
    fetch_chk("f_oor", 32'h100, 32'h0000_0013, 1'b0, 1'b1);
    fetch_chk("f_both", 32'h102, 32'h0000_0013, 1'b1, 1'b1);
    ld("ld_oor", 32'h100, 32'hDEAD_BEEF, 1'b1);
    tick();
    chk("ld_err_pulse", 32'(bus0.ld_err), 32'd0);
    fetch_chk("after_oor_ld", 32'h0, 32'h0070_0113, 1'b0, 1'b0);
    ld("ld_mis", 32'h6, 32'hCAFE_F00D, 1'b1);
    fetch_chk("after_mis_ld", 32'h4, 32'h0020_8193, 1'b0, 1'b0);

    // Same-index collision is read-first.
    ld("ld_c", 32'hC, 32'hAAAA_AAAA, 1'b0);
    bus0.ld_valid   = 1'b1; bus0.ld_addr = 32'hC; bus0.ld_data = 32'hBBBB_BBBB;
    bus0.fetch_req  = 1'b1; bus0.fetch_addr = 32'hC;
    tick();
    bus0.ld_valid = 1'b0;
    chk("coll_old", bus0.fetch_instr, 32'hAAAA_AAAA);
    chk("coll_ld_err", 32'(bus0.ld_err), 32'd0);
    tick();
    bus0.fetch_req = 1'b0;
    chk("coll_new", bus0.fetch_instr, 32'hBBBB_BBBB);

    // Load and fetch to different indices in one cycle.
    bus0.ld_valid   = 1'b1; bus0.ld_addr = 32'h10; bus0.ld_data = 32'h1111_1111;
    bus0.fetch_req  = 1'b1; bus0.fetch_addr = 32'h4;
    tick();
    bus0.ld_valid = 1'b0; bus0.fetch_req = 1'b0;
    chk("indep_fetch", bus0.fetch_instr, 32'h0020_8193);
    fetch_chk("indep_ld", 32'h10, 32'h1111_1111, 1'b0, 1'b0);

    // Reset with a fetch response and a load error pending.
    bus0.fetch_req  = 1'b1; bus0.fetch_addr = 32'h4;
    bus0.ld_valid   = 1'b1; bus0.ld_addr = 32'h100; bus0.ld_data = 32'h0;
    tick();
    bus0.fetch_req = 1'b0; bus0.ld_valid = 1'b0;
    chk("pend_valid", 32'(bus0.fetch_valid), 32'd1);
    chk("pend_ld_err", 32'(bus0.ld_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus0.fetch_valid), 32'd0);
    chk("arst_instr", bus0.fetch_instr, 32'd0);
    chk("arst_ld_err", 32'(bus0.ld_err), 32'd0);
    chk("arst_ready", 32'(bus0.ready), 32'd0);
    chk("arst_flags", {30'd0, bus0.fetch_misalign, bus0.fetch_oor}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("part_clr_ready", 32'(bus0.ready), 32'd0);
    end

    // Reset again with clr_cnt at 20: clear restarts from index 0.
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_ready", 32'(bus0.ready), 32'd0);
    tick();
    rst_n = 1'b1;
    bus0.fetch_req  = 1'b1;
    bus0.fetch_addr = 32'h10;
    wait_clear(1'b1);
    tick();
    bus0.fetch_req = 1'b0;
    chk("reclr_valid", 32'(bus0.fetch_valid), 32'd1);
    chk("reclr_instr", bus0.fetch_instr, 32'h0000_0013);

    // DEPTH=5, no clear on reset.
    bus1.ld_valid = 1'b1; bus1.ld_addr = 32'h10; bus1.ld_data = 32'h1234_5678;
    tick();
    bus1.ld_valid = 1'b0;
    chk("nc_ld_err", 32'(bus1.ld_err), 32'd0);
    bus1.fetch_req = 1'b1; bus1.fetch_addr = 32'h10;
    tick();
    bus1.fetch_addr = 32'h14;
    chk("nc_last_valid", 32'(bus1.fetch_valid), 32'd1);
    chk("nc_last_oor", 32'(bus1.fetch_oor), 32'd0);
    chk("nc_last_instr", bus1.fetch_instr, 32'h1234_5678);
    tick();
    bus1.fetch_req = 1'b0;
    chk("nc_past_oor", 32'(bus1.fetch_oor), 32'd1);
    chk("nc_past_instr", bus1.fetch_instr, 32'h0000_0013);
    bus1.ld_valid = 1'b1; bus1.ld_addr = 32'h14; bus1.ld_data = 32'h0;
    tick();
    bus1.ld_valid = 1'b0;
    chk("nc_oor_ld_err", 32'(bus1.ld_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
